// File: rtl/pipe_ctrl_gen_pkg.sv
// pipe_ctrl_gen_pkg: shared defines for the pipeline controller.
//   Exception codes, pipeline stage indices, ZeroWord, the store-phase
//   enum and a helper producing a low-bit stall mask.
package pipe_ctrl_gen_pkg;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_INV  = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;
    localparam logic [31:0] EXC_TLB  = 32'h0000_000f;

    localparam int unsigned STAGE_PC  = 0;
    localparam int unsigned STAGE_IF  = 1;
    localparam int unsigned STAGE_ID  = 2;
    localparam int unsigned STAGE_EX  = 3;
    localparam int unsigned STAGE_MEM = 4;
    localparam int unsigned STAGE_WB  = 5;

    typedef enum logic [1:0] {
        SP_IDLE   = 2'd0,
        SP_WAIT   = 2'd1,
        SP_COMMIT = 2'd2
    } store_phase_e;

    // Bits [s:0] set; holding a stage also holds everything upstream of it.
    function automatic logic [31:0] stage_mask(input int unsigned s);
        logic [32:0] m;
        m = (33'd1 << (s + 1)) - 33'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/pipe_ctrl_gen_if.sv
// pipe_ctrl_gen_if: bundle of pipeline-side requests and controller outputs.
//   master: pipeline side (drives stall requests, store flag, exception, EPC)
//   slave : pipe_ctrl_gen (drives stall, flush, new_pc, mem_we_o,
//           store_busy, perf_stall_cnt)
interface pipe_ctrl_gen_if #(
    parameter int unsigned NSTAGE = 6
);
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              mem_we_i;
    logic [31:0]       excepttype_i;
    logic [31:0]       cp0_epc_i;
    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              mem_we_o;
    logic              store_busy;
    logic [31:0]       perf_stall_cnt;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, mem_we_i,
               excepttype_i, cp0_epc_i,
        input  stall, flush, new_pc, mem_we_o, store_busy, perf_stall_cnt
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, mem_we_i,
               excepttype_i, cp0_epc_i,
        output stall, flush, new_pc, mem_we_o, store_busy, perf_stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_gen_store_seq.sv
// pipe_ctrl_gen_store_seq: multi-cycle store sequencer for the SRAM bus.
//   clk, rst      : clock, synchronous active-high reset
//   mem_we_i      : MEM stage holds a store
//   abort_i       : exception in MEM; drop any in-flight store
//   phase_o       : IDLE / WAIT (hold MEM) / COMMIT (strobe this cycle)
//   mem_we_o      : single write strobe per store
//   store_busy_o  : store sequence in progress
module pipe_ctrl_gen_store_seq
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int unsigned STORE_WAIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_we_i,
    input  logic         abort_i,
    output store_phase_e phase_o,
    output logic         mem_we_o,
    output logic         store_busy_o
);

    localparam logic [3:0] SW = STORE_WAIT[3:0];

    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        phase_o      = SP_IDLE;
        cnt_d        = '0;
        mem_we_o     = 1'b0;
        store_busy_o = 1'b0;
        if (!rst && !abort_i && mem_we_i) begin
            store_busy_o = 1'b1;
            if (cnt_q < SW) begin
                phase_o = SP_WAIT;
                cnt_d   = cnt_q + 4'd1;
            end else begin
                // Counter returns to 0, so a still-high mem_we_i starts a new store.
                phase_o  = SP_COMMIT;
                mem_we_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// pipe_ctrl_gen: 5-stage pipeline controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pipe_ctrl_gen_if.slave
//     in : stallreq_id/ex/mem, mem_we_i, excepttype_i, cp0_epc_i
//     out: stall[NSTAGE], flush, new_pc, mem_we_o, store_busy, perf_stall_cnt
//   Merges stall requests, sequences stores, resolves exceptions into
//   flush + redirect PC, and counts stalled cycles.
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int unsigned NSTAGE     = 6,
    parameter int unsigned ID_IDX     = STAGE_ID,
    parameter int unsigned EX_IDX     = STAGE_EX,
    parameter int unsigned MEM_IDX    = STAGE_MEM,
    parameter int unsigned STORE_WAIT = 1,
    parameter logic [31:0] INT_VEC    = 32'h8000_1180,
    parameter logic [31:0] EXC_VEC    = 32'h8000_142c
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_gen_if.slave  bus
);

    localparam logic [31:0] ID_MASK32  = stage_mask(ID_IDX);
    localparam logic [31:0] EX_MASK32  = stage_mask(EX_IDX);
    localparam logic [31:0] MEM_MASK32 = stage_mask(MEM_IDX);
    localparam logic [NSTAGE-1:0] ID_MASK  = ID_MASK32[NSTAGE-1:0];
    localparam logic [NSTAGE-1:0] EX_MASK  = EX_MASK32[NSTAGE-1:0];
    localparam logic [NSTAGE-1:0] MEM_MASK = MEM_MASK32[NSTAGE-1:0];

    logic              exc;
    store_phase_e      phase;
    logic              seq_we;
    logic              seq_busy;
    logic [NSTAGE-1:0] stall_v;
    logic              flush_v;
    logic [31:0]       new_pc_v;
    logic [31:0]       perf_cnt_q, perf_cnt_d;

    assign exc = (bus.excepttype_i != ZeroWord);

    pipe_ctrl_gen_store_seq #(
        .STORE_WAIT (STORE_WAIT)
    ) u_store_seq (
        .clk          (clk),
        .rst          (rst),
        .mem_we_i     (bus.mem_we_i),
        .abort_i      (exc),
        .phase_o      (phase),
        .mem_we_o     (seq_we),
        .store_busy_o (seq_busy)
    );

    always_comb begin
        stall_v  = '0;
        flush_v  = 1'b0;
        new_pc_v = ZeroWord;
        if (!rst) begin
            if (exc) begin
                flush_v = 1'b1;
                case (bus.excepttype_i)
                    EXC_INT:  new_pc_v = INT_VEC;
                    EXC_ERET: new_pc_v = bus.cp0_epc_i;
                    EXC_SYS, EXC_INV, EXC_OV, EXC_TRAP, EXC_TLB:
                              new_pc_v = EXC_VEC;
                    default:  new_pc_v = EXC_VEC;
                endcase
            end else begin
                if (bus.stallreq_id)  stall_v = stall_v | ID_MASK;
                if (bus.stallreq_ex)  stall_v = stall_v | EX_MASK;
                if (bus.stallreq_mem) stall_v = stall_v | ID_MASK;
                if (phase == SP_WAIT)   stall_v = stall_v | MEM_MASK;
                if (phase == SP_COMMIT) stall_v = stall_v | EX_MASK;
            end
        end
    end

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (|stall_v) perf_cnt_d = perf_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) perf_cnt_q <= '0;
        else     perf_cnt_q <= perf_cnt_d;
    end

    assign bus.stall          = stall_v;
    assign bus.flush          = flush_v;
    assign bus.new_pc         = new_pc_v;
    assign bus.mem_we_o       = seq_we;
    assign bus.store_busy     = seq_busy;
    assign bus.perf_stall_cnt = perf_cnt_q;

endmodule
